mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- memory-access pipeline stage.
//
// Turns a load/store request from the execute stage into a byte-serial
// transfer on an 8-bit shared RAM port (little-endian, no alignment rule,
// 32-bit wrapping addresses). While the transfer runs the pipeline is
// stalled; loads write their extended result back in the one-cycle DONE
// state. Without a memory op the write-back fields pass straight through.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   rdy                 global ready; low freezes all state
//   ma_we, ma_re        store / load request (both high = store)
//   ma_width            funct3 access width (B/H/W/BU/HU)
//   ma_addr, ma_wdata   byte address and store data
//   we_in, waddr_in,
//   wdata_in            write-back fields from execute
//   bus_req, bus_grant  shared-memory arbitration handshake
//   ram_a, ram_dout,
//   ram_wr, ram_din     byte RAM port (ram_din valid one cycle after ram_a)
//   stall_req           pipeline stall request (combinational)
//   we, waddr, wdata    write-back outputs
// -----------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ma_we,
  input  logic        ma_re,
  input  logic [2:0]  ma_width,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  input  logic        we_in,
  input  logic [4:0]  waddr_in,
  input  logic [31:0] wdata_in,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        stall_req,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  k_reg, k_next;

  // Request fields latched when the request is accepted.
  logic        store_reg;
  logic [2:0]  width_reg;
  logic [31:0] addr_reg;
  logic [31:0] sdata_reg;
  logic        we_reg;
  logic [4:0]  waddr_reg;
  logic [31:0] ldata_reg;

  logic [2:0]  n_bytes;
  logic [2:0]  last_k;
  logic        request;
  logic        capture;
  logic [31:0] load_ext;

  assign request = ma_we | ma_re;

  // Byte count from the size bits; the reserved size 11 behaves as a word.
  always_comb begin
    n_bytes = 3'd4;
    case (width_reg[1:0])
      2'b00:   n_bytes = 3'd1;
      2'b01:   n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
  end

  // A load needs one extra cycle to pick up the last byte from the RAM.
  assign last_k  = store_reg ? (n_bytes - 3'd1) : n_bytes;
  assign capture = (state_reg == XFER) && !store_reg && rdy && (k_reg != 3'd0);

  // ---------------------------------------------------------------------------
  // State register and counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      k_reg     <= 3'd0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    if (rdy) begin
      case (state_reg)
        IDLE: if (request) state_next = REQ;
        REQ: begin
          if (bus_grant) begin
            state_next = XFER;
            k_next     = 3'd0;
          end
        end
        XFER: begin
          k_next = k_reg + 3'd1;
          if (k_reg == last_k) state_next = DONE;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch and load-byte capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_reg <= 1'b0;
      width_reg <= 3'd0;
      addr_reg  <= 32'd0;
      sdata_reg <= 32'd0;
      we_reg    <= 1'b0;
      waddr_reg <= 5'd0;
      ldata_reg <= 32'd0;
    end else begin
      if (state_reg == IDLE && rdy && request) begin
        store_reg <= ma_we;
        width_reg <= ma_width;
        addr_reg  <= ma_addr;
        sdata_reg <= ma_wdata;
        we_reg    <= we_in;
        waddr_reg <= waddr_in;
      end
      // ram_din now holds the byte addressed in the previous cycle (k-1).
      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          if (k_reg == 3'(i + 1)) ldata_reg[8*i +: 8] <= ram_din;
        end
      end
    end
  end

  // Sign-extend B/H unless funct3[2] marks the unsigned variant.
  always_comb begin
    load_ext = ldata_reg;
    case (width_reg[1:0])
      2'b00:   load_ext = {{24{~width_reg[2] & ldata_reg[7]}}, ldata_reg[7:0]};
      2'b01:   load_ext = {{16{~width_reg[2] & ldata_reg[15]}}, ldata_reg[15:0]};
      default: load_ext = ldata_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus / RAM outputs
  // ---------------------------------------------------------------------------
  assign bus_req = (state_reg == REQ) || (state_reg == XFER);
  assign ram_wr  = (state_reg == XFER) && store_reg && rdy;

  always_comb begin
    ram_a    = 32'd0;
    ram_dout = 8'd0;
    if (state_reg == XFER) begin
      // While a load is frozen, keep presenting the address of the byte still
      // owed (k-1), so ram_din is correct at the first cycle after rdy returns.
      if (!store_reg && !rdy && k_reg != 3'd0)
        ram_a = addr_reg + 32'(k_reg) - 32'd1;
      else
        ram_a = addr_reg + 32'(k_reg);
      if (store_reg) begin
        case (k_reg[1:0])
          2'd0: ram_dout = sdata_reg[7:0];
          2'd1: ram_dout = sdata_reg[15:8];
          2'd2: ram_dout = sdata_reg[23:16];
          default: ram_dout = sdata_reg[31:24];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall and write-back
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_req = 1'b0;
    case (state_reg)
      IDLE:    stall_req = request;
      REQ:     stall_req = 1'b1;
      XFER:    stall_req = 1'b1;
      default: stall_req = 1'b0;
    endcase
  end

  always_comb begin
    we    = we_in;
    waddr = waddr_in;
    wdata = wdata_in;
    if (state_reg == DONE) begin
      if (store_reg) begin
        we = 1'b0;
      end else begin
        we    = we_reg;
        waddr = waddr_reg;
        wdata = load_ext;
      end
    end else if (stall_req) begin
      we = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access.
//
// A 256-byte RAM (indexed by address[7:0]) answers the DUT's byte port with
// one cycle of read latency. A reference byte image is kept alongside it and
// every load result is predicted from that image plus the width rules.
// -----------------------------------------------------------------------------
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ma_we;
  logic        ma_re;
  logic [2:0]  ma_width;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic        we_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  logic        bus_req;
  logic        bus_grant;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stall_req;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  bit filled = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .ma_we     (ma_we),
    .ma_re     (ma_re),
    .ma_width  (ma_width),
    .ma_addr   (ma_addr),
    .ma_wdata  (ma_wdata),
    .we_in     (we_in),
    .waddr_in  (waddr_in),
    .wdata_in  (wdata_in),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din),
    .stall_req (stall_req),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: registered read, write on strobe.
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
      filled = 1;
    end
    ram_din <= mem[ram_a[7:0]];
    if (ram_wr) begin
      mem[ram_a[7:0]] = ram_dout;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One memory operation from request to the idle cycle after DONE.
  // Entered just after a rising edge with the DUT idle.
  task automatic do_op(input bit st, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] wa, input bit wen,
                       input int g, input int gap);
    int n, xlen, j, gap_at, gap_used, guard;
    logic [31:0] exp;
    n    = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
    xlen = st ? n : n + 1;
    gap_at = (gap < 0) ? -1 : gap % xlen;
    exp = 32'd0;
    for (int i = 0; i < n; i++) exp[8*i +: 8] = ref_mem[8'(a + 32'(i))];
    if (!w[2] && n == 1) exp = {{24{exp[7]}}, exp[7:0]};
    if (!w[2] && n == 2) exp = {{16{exp[15]}}, exp[15:0]};

    // IDLE with a request present
    ma_we = st; ma_re = st ? 1'($urandom_range(0, 1)) : 1'b1;
    ma_width = w; ma_addr = a; ma_wdata = d;
    we_in = wen; waddr_in = wa; wdata_in = $urandom;
    bus_grant = 1'b0; rdy = 1'b1;
    #1;
    chk("idle_stall", 32'(stall_req), 32'd1);
    chk("idle_we", 32'(we), 32'd0);
    @(posedge clk); #1;

    // Request has been latched: scramble every request input.
    ma_we = 1'b0; ma_re = 1'b0;
    ma_width = 3'($urandom); ma_addr = $urandom; ma_wdata = $urandom;
    waddr_in = 5'($urandom); we_in = 1'($urandom); wdata_in = $urandom;

    for (int r = 0; r <= g; r++) begin
      bus_grant = (r == g);
      #1;
      chk("req_bus_req", 32'(bus_req), 32'd1);
      chk("req_stall", 32'(stall_req), 32'd1);
      chk("req_ram_wr", 32'(ram_wr), 32'd0);
      @(posedge clk); #1;
    end

    j = 0; gap_used = 0; guard = 0;
    while (j < xlen && guard < 20) begin
      if (j == gap_at && gap_used < 2) begin
        rdy = 1'b0; gap_used++;
      end else begin
        rdy = 1'b1;
      end
      #1;
      chk("xfer_stall", 32'(stall_req), 32'd1);
      chk("xfer_we", 32'(we), 32'd0);
      if (!rdy) begin
        chk("hold_ram_wr", 32'(ram_wr), 32'd0);
      end else if (st) begin
        chk("st_ram_wr", 32'(ram_wr), 32'd1);
        chk("st_ram_a", ram_a, a + 32'(j));
        chk("st_ram_dout", 32'(ram_dout), 32'(d[8*j +: 8]));
      end else begin
        chk("ld_ram_wr", 32'(ram_wr), 32'd0);
        if (j < n) chk("ld_ram_a", ram_a, a + 32'(j));
      end
      if (rdy) j++;
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 20) chk("xfer_timeout", 32'(guard), 32'd0);

    // DONE
    rdy = 1'b1;
    bus_grant = 1'b0;
    #1;
    chk("done_stall", 32'(stall_req), 32'd0);
    chk("done_bus_req", 32'(bus_req), 32'd0);
    chk("done_ram_wr", 32'(ram_wr), 32'd0);
    if (st) begin
      chk("done_st_we", 32'(we), 32'd0);
      for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = d[8*i +: 8];
    end else begin
      chk("done_ld_we", 32'(we), 32'(wen));
      chk("done_ld_waddr", 32'(waddr), 32'(wa));
      chk("done_ld_wdata", wdata, exp);
    end
    $display("op %s w=%0d addr=%h data=%h grant_wait=%0d gap=%0d result=%h",
             st ? "ST" : "LD", w, a, st ? d : exp, g, gap_at, wdata);
    @(posedge clk); #1;

    // Back in IDLE with no request: pass-through, no restart.
    chk("post_stall", 32'(stall_req), 32'd0);
    chk("post_bus_req", 32'(bus_req), 32'd0);
    chk("post_we", 32'(we), 32'(we_in));
    chk("post_wdata", wdata, wdata_in);
  endtask

  initial begin
    logic [31:0] a, d;
    int cnt;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    rst = 1'b0; rdy = 1'b1; ma_we = 1'b0; ma_re = 1'b0; ma_width = 3'd0;
    ma_addr = 32'd0; ma_wdata = 32'd0; we_in = 1'b0; waddr_in = 5'd0;
    wdata_in = 32'd0; bus_grant = 1'b0;
    #3;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rel_ram_a", ram_a, 32'd0);
    chk("rel_ram_dout", 32'(ram_dout), 32'd0);
    chk("rel_stall", 32'(stall_req), 32'd0);

    // ADD pass-through
    we_in = 1'b1; waddr_in = 5'd3; wdata_in = 32'd7;
    #1;
    chk("pt_we", 32'(we), 32'd1);
    chk("pt_waddr", 32'(waddr), 32'd3);
    chk("pt_wdata", wdata, 32'd7);
    chk("pt_stall", 32'(stall_req), 32'd0);
    $display("pass-through we=%0d waddr=%0d wdata=%h", we, waddr, wdata);
    @(posedge clk); #1;

    // SW then LW back
    do_op(1, 3'b010, 32'h0000_0100, 32'hAABB_CCDD, 5'd1, 1'b1, 0, -1);
    do_op(0, 3'b010, 32'h0000_0100, 32'd0, 5'd9, 1'b1, 0, -1);
    // LB / LBU of 0x80
    do_op(1, 3'b000, 32'h0000_0020, 32'h0000_0080, 5'd0, 1'b0, 0, -1);
    do_op(0, 3'b000, 32'h0000_0020, 32'd0, 5'd5, 1'b1, 0, -1);
    do_op(0, 3'b100, 32'h0000_0020, 32'd0, 5'd5, 1'b1, 0, -1);
    // LH across the address wrap
    do_op(1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0034, 5'd0, 1'b0, 0, -1);
    do_op(1, 3'b000, 32'h0000_0000, 32'h0000_0012, 5'd0, 1'b0, 0, -1);
    do_op(0, 3'b001, 32'hFFFF_FFFF, 32'd0, 5'd6, 1'b1, 0, -1);
    // Grant withheld 3 cycles; LW with rdy low mid-transfer
    do_op(1, 3'b010, 32'h0000_0060, 32'h1234_5678, 5'd0, 1'b0, 3, -1);
    do_op(0, 3'b010, 32'h0000_0060, 32'd0, 5'd7, 1'b1, 0, 2);
    do_op(0, 3'b101, 32'h0000_0062, 32'd0, 5'd8, 1'b1, 1, 4);

    // Reset in the middle of a store (data matches RAM so contents stay known)
    a = 32'h0000_0040;
    d = {ref_mem[8'h43], ref_mem[8'h42], ref_mem[8'h41], ref_mem[8'h40]};
    ma_we = 1'b1; ma_re = 1'b0; ma_width = 3'b010; ma_addr = a; ma_wdata = d;
    bus_grant = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    ma_we = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("mid_ram_wr", 32'(ram_wr), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_ram_wr", 32'(ram_wr), 32'd0);
    chk("abort_bus_req", 32'(bus_req), 32'd0);
    chk("abort_stall", 32'(stall_req), 32'd0);
    cnt = wr_cnt;
    #1;
    rst = 1'b1;
    #1;
    chk("abort_ram_a", ram_a, 32'd0);
    chk("abort_ram_dout", 32'(ram_dout), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_idle_stall", 32'(stall_req), 32'd0);
      chk("abort_idle_bus_req", 32'(bus_req), 32'd0);
    end
    chk("abort_no_writes", 32'(wr_cnt), 32'(cnt));
    $display("reset abort: writes after reset=%0d", wr_cnt - cnt);
    bus_grant = 1'b0;

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                       : $urandom;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
            5'($urandom), 1'($urandom), $urandom_range(0, 3),
            ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
